// File: rtl/spi_master_if.sv
// Byte-level request/response and SPI pin bundle for spi_master.
// The master modport belongs to the shifter; the slave modport belongs to whoever issues bytes and models the SPI device.
interface spi_master_if;
  logic       start;
  logic [7:0] tx_byte;
  logic       hold_cs;
  logic       busy;
  logic       done;
  logic [7:0] rx_byte;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic       ss;

  modport master (
    input  start, tx_byte, hold_cs, miso,
    output busy, done, rx_byte, sck, mosi, ss
  );

  modport slave (
    output start, tx_byte, hold_cs, miso,
    input  busy, done, rx_byte, sck, mosi, ss
  );
endinterface

// File: rtl/spi_master.sv
// Mode-0 SPI byte master: the first SCK rise comes 1+CLK_DIV cycles after start, and done pulses 1+16*CLK_DIV cycles after start.
// A start is accepted only in IDLE; a start raised while busy is dropped. ss can be held low across bytes with hold_cs.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, CS_GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     r_state, w_next;
  logic [7:0] r_div;
  logic [2:0] r_bit;
  logic [6:0] r_tx;
  logic [7:0] r_shift;
  logic [7:0] r_rx;
  logic       r_hold;
  logic       r_sck;
  logic       r_mosi;
  logic       r_ss;
  logic       r_done;
  logic       w_tick;

  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // The SHIFT state is held through the done cycle, so busy stays high while done pulses.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = SHIFT;
      SHIFT:   if (r_done)    w_next = r_hold ? IDLE : CS_GAP;
      CS_GAP:  if (w_tick)    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div   <= 8'd0;
      r_bit   <= 3'd0;
      r_tx    <= 7'd0;
      r_shift <= 8'd0;
      r_rx    <= 8'd0;
      r_hold  <= 1'b0;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_ss    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_tx   <= bus.tx_byte[6:0];
            r_mosi <= bus.tx_byte[7];
            r_hold <= bus.hold_cs;
            r_ss   <= 1'b0;
            r_sck  <= 1'b0;
            r_div  <= 8'd0;
            r_bit  <= 3'd0;
          end
        end
        SHIFT: begin
          if (r_done) begin
            r_div <= 8'd0;
            if (!r_hold) r_ss <= 1'b1;
          end else if (w_tick) begin
            r_div <= 8'd0;
            r_sck <= ~r_sck;
            if (!r_sck) begin
              r_shift <= {r_shift[6:0], bus.miso};
            end else if (r_bit == 3'd7) begin
              // The 8th falling edge ends the byte; mosi keeps its last bit.
              r_done <= 1'b1;
              r_rx   <= r_shift;
            end else begin
              r_bit  <= r_bit + 3'd1;
              r_mosi <= r_tx[6];
              r_tx   <= {r_tx[5:0], 1'b0};
            end
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        CS_GAP: begin
          r_div <= w_tick ? 8'd0 : r_div + 8'd1;
        end
        default: r_div <= 8'd0;
      endcase
    end
  end

  assign bus.busy    = (r_state != IDLE);
  assign bus.done    = r_done;
  assign bus.rx_byte = r_rx;
  assign bus.sck     = r_sck;
  assign bus.mosi    = r_mosi;
  assign bus.ss      = r_ss;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master, with the divider set to 4 (dut a) and to 2 (dut b).
// The expected cycle numbers are hand-computed and counted from the clock edge that accepts start (edge 0).
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       loop_a = 1'b1;
  logic       slv_clr = 1'b1;
  logic [7:0] slv_byte = 8'h3C;
  logic [2:0] slv_cnt;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  spi_master_if ifa();
  spi_master_if ifb();

  spi_master #(.CLK_DIV(4)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
  spi_master #(.CLK_DIV(2)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // Slave model: it presents the next lower bit after each falling edge of SCK.
  always @(negedge ifa.sck or posedge slv_clr) begin
    if (slv_clr) slv_cnt <= 3'd0;
    else         slv_cnt <= slv_cnt + 3'd1;
  end

  assign ifa.miso = loop_a ? ifa.mosi : slv_byte[3'd7 - slv_cnt];
  assign ifb.miso = ifb.mosi;

  wire       g_sck  = sel ? ifb.sck  : ifa.sck;
  wire       g_mosi = sel ? ifb.mosi : ifa.mosi;
  wire       g_ss   = sel ? ifb.ss   : ifa.ss;
  wire       g_busy = sel ? ifb.busy : ifa.busy;
  wire       g_done = sel ? ifb.done : ifa.done;
  wire [7:0] g_rx   = sel ? ifb.rx_byte : ifa.rx_byte;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic st, input logic [7:0] tx, input logic hold);
    if (s) begin
      ifb.start = st; ifb.tx_byte = tx; ifb.hold_cs = hold;
    end else begin
      ifa.start = st; ifa.tx_byte = tx; ifa.hold_cs = hold;
    end
  endtask

  // Runs one byte and stops at the first cycle with busy low. tx_byte and hold_cs are inverted right after acceptance.
  task automatic xfer(input logic s, input logic [7:0] tx, input logic hold, input int div,
                      input int inj_cyc, input logic [7:0] inj_tx,
                      output int done_cyc, output int ndone, output int rises, output int rise1,
                      output logic [7:0] mbits, output int ss_first, output int ss_cnt,
                      output int busy_lo);
    logic psck;
    bit   fin;
    sel = s;
    done_cyc = -1; ndone = 0; rises = 0; rise1 = -1; mbits = 8'h00;
    ss_first = -1; ss_cnt = 0; busy_lo = -1; psck = 1'b0; fin = 1'b0;
    @(posedge clk); #1;
    drive(s, 1'b1, tx, hold);
    @(posedge clk); #1;
    drive(s, 1'b0, ~tx, ~hold);
    for (int c = 1; c <= 20 * div + 20 && !fin; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("c1_ss", g_ss, 0);
        check("c1_busy", g_busy, 1);
        check("c1_sck", g_sck, 0);
        check("c1_mosi", g_mosi, tx[7]);
      end
      if (g_sck && !psck) begin
        rises++;
        if (rise1 < 0) rise1 = c;
        mbits = {mbits[6:0], g_mosi};
      end
      psck = g_sck;
      if (g_done) begin ndone++; done_cyc = c; end
      if (g_busy && g_ss) begin
        ss_cnt++;
        if (ss_first < 0) ss_first = c;
      end
      if (!g_busy) begin busy_lo = c; fin = 1'b1; end
      if (c == inj_cyc)          drive(s, 1'b1, inj_tx, 1'b1);
      else if (c == inj_cyc + 1) drive(s, 1'b0, inj_tx, 1'b1);
    end
    if (!fin) check("timeout", 0, 1);
  endtask

  int         dc, nd, rs, r1, sf, sc, bl, rs_tot;
  logic [7:0] mb;

  initial begin
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_ss", ifa.ss, 1);
    check("rst_sck", ifa.sck, 0);
    check("rst_mosi", ifa.mosi, 0);
    check("rst_busy", ifa.busy, 0);
    check("rst_done", ifa.done, 0);
    check("rst_rx", ifa.rx_byte, 8'h00);
    check("rst_ss_b", ifb.ss, 1);
    rst = 1'b0;
    slv_clr = 1'b0;

    // Loopback of A5 with ss released at the end of the byte
    xfer(1'b0, 8'hA5, 1'b0, 4, -1, 8'h00, dc, nd, rs, r1, mb, sf, sc, bl);
    check("lb_done_cyc", dc, 65);
    check("lb_ndone", nd, 1);
    check("lb_rises", rs, 8);
    check("lb_rise1", r1, 5);
    check("lb_mosi", mb, 8'hA5);
    check("lb_rx", ifa.rx_byte, 8'hA5);
    check("lb_ss_first", sf, 66);
    check("lb_ss_cnt", sc, 4);
    check("lb_busy_lo", bl, 70);

    // The slave returns 3C while the master sends FF
    loop_a = 1'b0;
    slv_clr = 1'b1; #1; slv_clr = 1'b0;
    xfer(1'b0, 8'hFF, 1'b0, 4, -1, 8'h00, dc, nd, rs, r1, mb, sf, sc, bl);
    check("slv_mosi", mb, 8'hFF);
    check("slv_rx", ifa.rx_byte, 8'h3C);
    check("slv_ndone", nd, 1);
    check("slv_done_cyc", dc, 65);
    loop_a = 1'b1;

    // Two bytes back to back, with ss held low between them
    xfer(1'b0, 8'h12, 1'b1, 4, -1, 8'h00, dc, nd, rs, r1, mb, sf, sc, bl);
    rs_tot = rs;
    check("b1_done_cyc", dc, 65);
    check("b1_busy_lo", bl, 66);
    check("b1_ss_cnt", sc, 0);
    check("b1_rx", ifa.rx_byte, 8'h12);
    check("b1_ss_held", ifa.ss, 0);
    @(negedge clk);
    check("b1_ss_idle", ifa.ss, 0);
    xfer(1'b0, 8'h34, 1'b0, 4, -1, 8'h00, dc, nd, rs, r1, mb, sf, sc, bl);
    rs_tot += rs;
    check("b2_rises_total", rs_tot, 16);
    check("b2_ndone", nd, 1);
    check("b2_rx", ifa.rx_byte, 8'h34);
    check("b2_ss_first", sf, 66);
    check("b2_busy_lo", bl, 70);

    // A start raised during a transfer is ignored
    xfer(1'b0, 8'h5A, 1'b0, 4, 20, 8'hC3, dc, nd, rs, r1, mb, sf, sc, bl);
    check("ign_rx", ifa.rx_byte, 8'h5A);
    check("ign_mosi", mb, 8'h5A);
    check("ign_ndone", nd, 1);
    check("ign_done_cyc", dc, 65);
    repeat (3) @(negedge clk);
    check("ign_no_queue", ifa.busy, 0);

    // Divider of 2, sending 81
    xfer(1'b1, 8'h81, 1'b0, 2, -1, 8'h00, dc, nd, rs, r1, mb, sf, sc, bl);
    check("d2_done_cyc", dc, 33);
    check("d2_rise1", r1, 3);
    check("d2_rises", rs, 8);
    check("d2_mosi", mb, 8'h81);
    check("d2_rx", ifb.rx_byte, 8'h81);
    check("d2_ss_cnt", sc, 2);
    check("d2_busy_lo", bl, 36);

    // Reset asserted at cycle 30 of a transfer
    sel = 1'b0;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 8'hA5, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (31) @(negedge clk);
    check("mid_sck_before", ifa.sck, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_ss", ifa.ss, 1);
    check("mid_rst_sck", ifa.sck, 0);
    check("mid_rst_busy", ifa.busy, 0);
    check("mid_rst_done", ifa.done, 0);
    check("mid_rst_rx", ifa.rx_byte, 8'h00);
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (ifa.done) nd++;
    end
    check("mid_rst_nodone", nd, 0);
    rst = 1'b0;

    // After reset, the first transfer has the normal timing
    xfer(1'b0, 8'h96, 1'b0, 4, -1, 8'h00, dc, nd, rs, r1, mb, sf, sc, bl);
    check("post_done_cyc", dc, 65);
    check("post_rx", ifa.rx_byte, 8'h96);
    check("post_busy_lo", bl, 70);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
